// File: rtl/qei_pkg.sv
// Shared constants for the quadrature encoder front end: Gray states, direction codes, FSM states.
package qei_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef logic [0:0] qei_state_t;
  localparam qei_state_t INIT  = 1'b0;
  localparam qei_state_t TRACK = 1'b1;

  // Forward successor in the 00 -> 01 -> 11 -> 10 -> 00 cycle.
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      QS_00:   fwd_next = QS_01;
      QS_01:   fwd_next = QS_11;
      QS_11:   fwd_next = QS_10;
      default: fwd_next = QS_00;
    endcase
  endfunction

endpackage

// File: rtl/qei_glitch_filter.sv
// One encoder channel: synchroniser chain plus stability counter; load forces filt to the synced value.
// Latency SYNC_STAGES + FILT_LEN cycles pin-to-filt; no backpressure.
module qei_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  input  logic load,
  output logic sync_out,
  output logic filt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             cnt;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt    <= '0;
      filt   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (load) begin
        filt <= sync_out;
        cnt  <= '0;
      end else if (sync_out == filt) begin
        cnt <= '0;
      end else if (cnt == 8'(FILT_LEN - 1)) begin
        // FILT_LEN consecutive differing samples seen, including this one.
        filt <= ~filt;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/qei_input_conditioner.sv
// Quadrature encoder front end: sync + glitch filter A/B (and Z under QEI_INDEX_EN), Gray decode to step pulses.
// Step pulse 1 cycle after filtered change (SYNC_STAGES + FILT_LEN + 1 from pin); no backpressure.
module qei_input_conditioner
  import qei_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 8,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 enc_z,
  input  logic                 err_clr,
  output logic                 ready,
  output logic                 a_filt,
  output logic                 b_filt,
  output logic                 step_valid,
  output logic                 step_dir,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 index_pulse
);

  localparam int SETTLE = SYNC_STAGES + FILT_LEN;
  localparam int SW     = $clog2(SETTLE + 1);

  qei_state_t     state;
  logic [SW-1:0]  settle_cnt;
  logic           load;
  logic           a_s, b_s;
  logic [1:0]     prev, cur, delta;

  assign load  = (state == INIT);
  assign ready = (state == TRACK);
  assign cur   = {a_filt, b_filt};
  assign delta = prev ^ cur;

  qei_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .reset_n(reset_n), .din(enc_a), .load(load), .sync_out(a_s), .filt(a_filt)
  );

  qei_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .reset_n(reset_n), .din(enc_b), .load(load), .sync_out(b_s), .filt(b_filt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= INIT;
      settle_cnt <= '0;
      prev       <= QS_00;
      step_valid <= 1'b0;
      step_dir   <= DIR_REV;
      err_flag   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      step_valid <= 1'b0;
      if (state == INIT) begin
        // Track what the filters load this cycle so the first TRACK compare sees no change.
        prev <= {a_s, b_s};
        if (settle_cnt == SW'(SETTLE - 1)) state <= TRACK;
        else                                settle_cnt <= settle_cnt + 1'b1;
      end else begin
        prev <= cur;
        if (delta == 2'b01 || delta == 2'b10) begin
          step_valid <= 1'b1;
          step_dir   <= (cur == fwd_next(prev)) ? DIR_FWD : DIR_REV;
        end
      end

      if (state == TRACK && delta == 2'b11) begin
        err_flag <= 1'b1;
        if (err_clr)                              err_cnt <= ERR_CNT_W'(1);
        else if (err_cnt != {ERR_CNT_W{1'b1}})    err_cnt <= err_cnt + 1'b1;
      end else if (err_clr) begin
        err_flag <= 1'b0;
        err_cnt  <= '0;
      end
    end
  end

`ifdef QEI_INDEX_EN
  logic z_s, z_filt, z_prev;

  qei_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_z (
    .clk(clk), .reset_n(reset_n), .din(enc_z), .load(load), .sync_out(z_s), .filt(z_filt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      z_prev      <= 1'b0;
      index_pulse <= 1'b0;
    end else if (state == INIT) begin
      z_prev      <= z_s;
      index_pulse <= 1'b0;
    end else begin
      z_prev      <= z_filt;
      index_pulse <= z_filt & ~z_prev;
    end
  end
`else
  logic unused_z;
  assign unused_z    = enc_z;
  assign index_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_qei_input_conditioner.sv
// Directed bench for qei_input_conditioner (SYNC_STAGES=2, FILT_LEN=8, ERR_CNT_W=8); expects the
// index pulse only when QEI_INDEX_EN is defined.
module tb_qei_input_conditioner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enc_a = 1'b1, enc_b = 1'b1, enc_z = 1'b0, err_clr = 1'b0;
  logic       ready, a_filt, b_filt, step_valid, step_dir, err_flag, index_pulse;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  qei_input_conditioner #(.SYNC_STAGES(2), .FILT_LEN(8), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .err_clr(err_clr), .ready(ready), .a_filt(a_filt), .b_filt(b_filt),
    .step_valid(step_valid), .step_dir(step_dir), .err_flag(err_flag),
    .err_cnt(err_cnt), .index_pulse(index_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one pin change, hold 20 cycles, expect exactly one step 11 cycles later.
  task automatic step_check(input string tag, input logic na, input logic nb, input logic exp_dir);
    int n = 0, pos = 0;
    logic d = 1'bx;
    enc_a = na;
    enc_b = nb;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step_valid) begin
        n++;
        pos = i;
        d   = step_dir;
      end
    end
    chk({tag, "_count"}, n, 1);
    chk({tag, "_lat"}, pos, 11);
    chk({tag, "_dir"}, {31'b0, d}, {31'b0, exp_dir});
  endtask

  initial begin
    int n, bad, pos;

    // Reset with both pins high
    repeat (3) tick();
    chk("rst_ready", ready, 0);
    chk("rst_afilt", a_filt, 0);
    chk("rst_step", step_valid, 0);
    chk("rst_errcnt", err_cnt, 0);
    reset_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (step_valid || err_flag) n++;
    end
    chk("settle_ready_early", ready, 0);
    tick();
    chk("settle_ready", ready, 1);
    chk("settle_afilt", a_filt, 1);
    chk("settle_bfilt", b_filt, 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (step_valid || err_flag) n++;
    end
    chk("settle_no_step_err", n, 0);

    // Reverse 11->01->00->10->11, then forward 11->10->00->01->11
    step_check("rev1", 1'b0, 1'b1, 1'b0);
    step_check("rev2", 1'b0, 1'b0, 1'b0);
    step_check("rev3", 1'b1, 1'b0, 1'b0);
    step_check("rev4", 1'b1, 1'b1, 1'b0);
    step_check("fwd1", 1'b1, 1'b0, 1'b1);
    step_check("fwd2", 1'b0, 1'b0, 1'b1);
    step_check("fwd3", 1'b0, 1'b1, 1'b1);
    step_check("fwd4", 1'b1, 1'b1, 1'b1);
    chk("seq_errflag", err_flag, 0);

    // 5-cycle glitch on A must be rejected
    n = 0;
    bad = 0;
    enc_a = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) enc_a = 1'b1;
      tick();
      if (step_valid) n++;
      if (a_filt !== 1'b1) bad++;
    end
    chk("glitch_step", n, 0);
    chk("glitch_afilt", bad, 0);
    chk("glitch_errcnt", err_cnt, 0);

    // 300 simultaneous toggles: counter must saturate at 255, not wrap
    n = 0;
    for (int k = 0; k < 300; k++) begin
      enc_a = ~enc_a;
      enc_b = ~enc_b;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (step_valid) n++;
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (step_valid) n++;
    end
    chk("illegal_step", n, 0);
    chk("illegal_flag", err_flag, 1);
    chk("illegal_sat", err_cnt, 255);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_flag", err_flag, 0);
    chk("clr_cnt", err_cnt, 0);

    // err_clr coincident with an illegal decode: set wins
    enc_a = 1'b0;
    enc_b = 1'b0;
    repeat (10) tick();
    chk("coinc_pre_cnt", err_cnt, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("coinc_flag", err_flag, 1);
    chk("coinc_cnt", err_cnt, 1);

    // Reset mid-stream while a B edge is still in the filter
    enc_b = 1'b1;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    chk("mrst_ready", ready, 0);
    chk("mrst_dir", step_dir, 0);
    chk("mrst_flag", err_flag, 0);
    chk("mrst_cnt", err_cnt, 0);
    chk("mrst_bfilt", b_filt, 0);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (step_valid || err_flag) n++;
    end
    chk("mrst_no_spurious", n, 0);
    chk("mrst_ready_again", ready, 1);
    chk("mrst_state", {a_filt, b_filt}, 2'b01);
    step_check("mrst_fwd", 1'b1, 1'b1, 1'b1);

    // Index pulse from a 20-cycle Z pulse
    n = 0;
    pos = 0;
    enc_z = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 21) enc_z = 1'b0;
      tick();
      if (index_pulse) begin
        n++;
        pos = i;
      end
    end
`ifdef QEI_INDEX_EN
    chk("index_count", n, 1);
    chk("index_lat", pos, 11);
`else
    chk("index_count", n, 0);
    chk("index_lat", pos, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
